// File: rtl/alu_seq_ctrlr_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_ctrlr_pkg
// Shared definitions for the ALU sequencing controller:
//   - state_t            : controller state encoding (IDLE / EXEC / RESP)
//   - SEL_RHS_*          : rhs operand mux select codes
//   - DEFAULT_MULTI_LAT  : default execute latency of a multi-cycle op
//   - CNT_W              : latency counter width (covers MULTI_LAT up to 15)
//   - exec_load()        : latency counter load value for a newly issued op
// ----------------------------------------------------------------------------
package alu_seq_ctrlr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_t;

   localparam logic [1:0] SEL_RHS_SHAMT_REG = 2'b00;
   localparam logic [1:0] SEL_RHS_REG       = 2'b01;
   localparam logic [1:0] SEL_RHS_SHAMT_IMM = 2'b10;
   localparam logic [1:0] SEL_RHS_IMM       = 2'b11;

   localparam int DEFAULT_MULTI_LAT = 4;
   localparam int CNT_W             = 4;

   // The counter holds "EXEC cycles remaining after this one", so a
   // single-cycle op loads 0 and a multi-cycle op loads latency-1.
   function automatic logic [CNT_W-1:0] exec_load(input logic multi, input int lat);
      logic [CNT_W-1:0] val;
      val = '0;
      if (multi) begin
         val = CNT_W'(lat - 1);
      end
      return val;
   endfunction

endpackage

// File: rtl/alu_seq_ctrlr_sel_decode.sv
// ----------------------------------------------------------------------------
// alu_sel_decode
// Purely combinational map from the latched op class to the ALU operand
// mux selects.
//   op_shift  in  1  latched "op is a shift"
//   op_imm    in  1  latched "rhs is immediate"
//   lhs_ctrl  out 1  lhs mux select (1 = shift-amount path, 0 = register)
//   rhs_ctrl  out 2  rhs mux select (SEL_RHS_* codes)
// ----------------------------------------------------------------------------
module alu_sel_decode
   import alu_seq_ctrlr_pkg::*;
(
   input  logic       op_shift,
   input  logic       op_imm,
   output logic       lhs_ctrl,
   output logic [1:0] rhs_ctrl
);

   always_comb begin
      lhs_ctrl = 1'b0;
      rhs_ctrl = SEL_RHS_REG;
      case ({op_shift, op_imm})
         2'b11: begin
            lhs_ctrl = 1'b1;
            rhs_ctrl = SEL_RHS_SHAMT_IMM;
         end
         2'b10: begin
            lhs_ctrl = 1'b1;
            rhs_ctrl = SEL_RHS_SHAMT_REG;
         end
         2'b01: begin
            lhs_ctrl = 1'b0;
            rhs_ctrl = SEL_RHS_IMM;
         end
         default: begin
            lhs_ctrl = 1'b0;
            rhs_ctrl = SEL_RHS_REG;
         end
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrlr.sv
// ----------------------------------------------------------------------------
// alu_seq_ctrlr
// Sequences one decoded ALU op at a time through EXEC (1 or MULTI_LAT
// cycles) and RESP (result offered until downstream takes it).
//   MULTI_LAT        param  execute cycles of a multi-cycle op (2..15)
//   w_clk            in  1  clock, rising edge
//   w_rst_n          in  1  asynchronous active-low reset
//   w_issue_valid    in  1  op offered by decode
//   w_issue_ready    out 1  op accepted this cycle
//   w_imm_op         in  1  rhs is immediate (sampled on handshake)
//   w_shift_op       in  1  op is a shift (sampled on handshake)
//   w_multi_op       in  1  op is multi-cycle (sampled on handshake)
//   w_stall          in  1  downstream cannot take a result
//   w_flush          in  1  discard in-flight op
//   w_alu_lhs_ctrl   out 1  lhs mux select
//   w_alu_rhs_ctrl   out 2  rhs mux select
//   w_alu_en         out 1  ALU working on the latched op
//   w_result_valid   out 1  result available for writeback
//   w_busy           out 1  controller not idle
// ----------------------------------------------------------------------------
module alu_seq_ctrlr
   import alu_seq_ctrlr_pkg::*;
#(
   parameter int MULTI_LAT = DEFAULT_MULTI_LAT
)
(
   input  logic       w_clk,
   input  logic       w_rst_n,
   input  logic       w_issue_valid,
   output logic       w_issue_ready,
   input  logic       w_imm_op,
   input  logic       w_shift_op,
   input  logic       w_multi_op,
   input  logic       w_stall,
   input  logic       w_flush,
   output logic       w_alu_lhs_ctrl,
   output logic [1:0] w_alu_rhs_ctrl,
   output logic       w_alu_en,
   output logic       w_result_valid,
   output logic       w_busy
);

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             op_shift_reg;
   logic             op_imm_reg;
   logic             handshake;

   // ------------------------------------------------------------------
   // State and counter registers
   // ------------------------------------------------------------------
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Op registers only move on an accepted issue, so the selects they
   // drive naturally hold their last values while idle.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         op_shift_reg <= 1'b0;
         op_imm_reg   <= 1'b0;
      end else if (handshake) begin
         op_shift_reg <= w_shift_op;
         op_imm_reg   <= w_imm_op;
      end
   end

   // ------------------------------------------------------------------
   // Next-state, counter and issue handshake
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      w_issue_ready = 1'b0;
      handshake     = 1'b0;

      case (state_reg)
         ST_IDLE: w_issue_ready = 1'b1;
         ST_RESP: w_issue_ready = !w_stall && !w_flush;
         default: w_issue_ready = 1'b0;
      endcase

      // In IDLE ready stays high during a flush, but the op must still be
      // dropped, hence the explicit flush term.
      handshake = w_issue_valid && w_issue_ready && !w_flush;

      case (state_reg)
         ST_IDLE: begin
            if (handshake) begin
               state_next = ST_EXEC;
               cnt_next   = exec_load(w_multi_op, MULTI_LAT);
            end
         end
         ST_EXEC: begin
            if (cnt_reg == '0) begin
               state_next = ST_RESP;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (!w_stall) begin
               if (handshake) begin
                  state_next = ST_EXEC;
                  cnt_next   = exec_load(w_multi_op, MULTI_LAT);
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase

      if (w_flush) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: all from registered state except w_issue_ready
   // ------------------------------------------------------------------
   assign w_alu_en       = (state_reg == ST_EXEC);
   assign w_result_valid = (state_reg == ST_RESP);
   assign w_busy         = (state_reg != ST_IDLE);

   alu_sel_decode u_sel_decode (
      .op_shift (op_shift_reg),
      .op_imm   (op_imm_reg),
      .lhs_ctrl (w_alu_lhs_ctrl),
      .rhs_ctrl (w_alu_rhs_ctrl)
   );

endmodule

// File: tb/tb_alu_seq_ctrlr.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_ctrlr
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model (remaining EXEC cycles plus a
// pending-result flag).
// ----------------------------------------------------------------------------
module tb_alu_seq_ctrlr;

   localparam int MLAT = 4;

   logic       w_clk;
   logic       w_rst_n;
   logic       w_issue_valid;
   logic       w_issue_ready;
   logic       w_imm_op;
   logic       w_shift_op;
   logic       w_multi_op;
   logic       w_stall;
   logic       w_flush;
   logic       w_alu_lhs_ctrl;
   logic [1:0] w_alu_rhs_ctrl;
   logic       w_alu_en;
   logic       w_result_valid;
   logic       w_busy;

   alu_seq_ctrlr #(.MULTI_LAT(MLAT)) dut (
      .w_clk          (w_clk),
      .w_rst_n        (w_rst_n),
      .w_issue_valid  (w_issue_valid),
      .w_issue_ready  (w_issue_ready),
      .w_imm_op       (w_imm_op),
      .w_shift_op     (w_shift_op),
      .w_multi_op     (w_multi_op),
      .w_stall        (w_stall),
      .w_flush        (w_flush),
      .w_alu_lhs_ctrl (w_alu_lhs_ctrl),
      .w_alu_rhs_ctrl (w_alu_rhs_ctrl),
      .w_alu_en       (w_alu_en),
      .w_result_valid (w_result_valid),
      .w_busy         (w_busy)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_exec_left;   // EXEC cycles still to run for the current op
   bit m_pending;     // result waiting to be taken
   bit m_shift;
   bit m_imm;

   // Observation helpers
   bit         last_hs;
   logic       seen_en, seen_rv, seen_busy, seen_ready, seen_lhs;
   logic [1:0] seen_rhs;
   int         en_count, rv_count;
   logic [1:0] en_rhs_q[$];
   logic       en_lhs_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected {lhs, rhs} straight from the operand selection table.
   function automatic logic [2:0] sel_of(input bit sh, input bit im);
      logic [2:0] r;
      if (sh && im)       r = {1'b1, 2'b10};
      else if (sh)        r = {1'b1, 2'b00};
      else if (im)        r = {1'b0, 2'b11};
      else                r = {1'b0, 2'b01};
      return r;
   endfunction

   task automatic model_reset();
      m_exec_left = 0;
      m_pending   = 0;
      m_shift     = 0;
      m_imm       = 0;
   endtask

   // One clock cycle: check at the falling edge, advance the model, then
   // return 1 time unit after the rising edge so the caller can drive inputs.
   task automatic cycle();
      logic [2:0] s;
      bit exp_busy, exp_ready;
      @(negedge w_clk);
      s         = sel_of(m_shift, m_imm);
      exp_busy  = (m_exec_left > 0) || m_pending;
      exp_ready = !exp_busy || (m_pending && !w_stall && !w_flush);
      check_val("ready",  w_issue_ready,  exp_ready);
      check_val("alu_en", w_alu_en,       m_exec_left > 0);
      check_val("rvalid", w_result_valid, m_pending);
      check_val("busy",   w_busy,         exp_busy);
      check_val("lhs",    w_alu_lhs_ctrl, s[2]);
      check_val("rhs",    w_alu_rhs_ctrl, s[1:0]);
      seen_en    = w_alu_en;
      seen_rv    = w_result_valid;
      seen_busy  = w_busy;
      seen_ready = w_issue_ready;
      seen_lhs   = w_alu_lhs_ctrl;
      seen_rhs   = w_alu_rhs_ctrl;
      if (w_alu_en === 1'b1) begin
         en_count++;
         en_rhs_q.push_back(w_alu_rhs_ctrl);
         en_lhs_q.push_back(w_alu_lhs_ctrl);
      end
      if (w_result_valid === 1'b1) rv_count++;

      last_hs = w_issue_valid && exp_ready && !w_flush;
      if (w_flush) begin
         m_exec_left = 0;
         m_pending   = 0;
      end else if (m_exec_left > 0) begin
         m_exec_left--;
         if (m_exec_left == 0) m_pending = 1;
      end else if (m_pending && w_stall) begin
         // result held
      end else begin
         m_pending = 0;
         if (last_hs) begin
            m_shift     = w_shift_op;
            m_imm       = w_imm_op;
            m_exec_left = w_multi_op ? MLAT : 1;
         end
      end
      @(posedge w_clk);
      #1;
   endtask

   task automatic issue_op(input logic sh, input logic im, input logic mu);
      int budget;
      budget        = 0;
      w_issue_valid = 1'b1;
      w_shift_op    = sh;
      w_imm_op      = im;
      w_multi_op    = mu;
      last_hs       = 0;
      while (!last_hs && budget < 40) begin
         cycle();
         budget++;
      end
      if (!last_hs) check_val("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle_inputs();
      w_issue_valid = 1'b0;
      w_shift_op    = 1'b0;
      w_imm_op      = 1'b0;
      w_multi_op    = 1'b0;
      w_stall       = 1'b0;
      w_flush       = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] sw_rhs [4];
      logic       sw_lhs [4];
      logic       sw_sh  [4];
      logic       sw_im  [4];
      sw_sh  = '{1'b1, 1'b1, 1'b0, 1'b0};
      sw_im  = '{1'b0, 1'b1, 1'b0, 1'b1};
      sw_rhs = '{2'b00, 2'b10, 2'b01, 2'b11};
      sw_lhs = '{1'b1, 1'b1, 1'b0, 1'b0};

      w_rst_n = 1'b0;
      idle_inputs();
      model_reset();

      // Reset values while held in reset
      #2;
      check_val("rst_lhs",  w_alu_lhs_ctrl, 0);
      check_val("rst_rhs",  w_alu_rhs_ctrl, 2'b01);
      check_val("rst_en",   w_alu_en,       0);
      check_val("rst_rv",   w_result_valid, 0);
      check_val("rst_busy", w_busy,         0);
      #10;
      w_rst_n = 1'b1;
      @(posedge w_clk);
      #1;
      cycle();
      check_val("rst_ready", seen_ready, 1);

      // Single-cycle add-reg: en at cycle 1, rvalid at 2, idle at 3
      issue_op(1'b0, 1'b0, 1'b0);
      w_issue_valid = 1'b0;
      cycle();
      check_val("add_en_c1", seen_en, 1);
      cycle();
      check_val("add_rv_c2", seen_rv, 1);
      check_val("add_rhs", seen_rhs, 2'b01);
      cycle();
      check_val("add_idle_c3", seen_busy, 0);

      // Shift-imm multi op: 4 EXEC cycles then result
      issue_op(1'b1, 1'b1, 1'b1);
      w_issue_valid = 1'b0;
      en_count = 0;
      rv_count = 0;
      repeat (MLAT) cycle();
      check_val("multi_en_cycles", en_count, MLAT);
      check_val("multi_no_early_rv", rv_count, 0);
      cycle();
      check_val("multi_rv", seen_rv, 1);
      check_val("multi_lhs", seen_lhs, 1);
      check_val("multi_rhs", seen_rhs, 2'b10);
      cycle();

      // Stall holds the result, then back-to-back issue
      issue_op(1'b0, 1'b1, 1'b0);
      w_shift_op = 1'b0;
      w_imm_op   = 1'b0;
      cycle();                      // EXEC, next op already offered
      w_stall  = 1'b1;
      rv_count = 0;
      repeat (3) begin
         cycle();
         check_val("stall_ready", seen_ready, 0);
         check_val("stall_rhs", seen_rhs, 2'b11);
      end
      w_stall = 1'b0;
      issue_op(1'b0, 1'b0, 1'b0);
      check_val("stall_rv_cycles", rv_count, 4);
      w_issue_valid = 1'b0;
      cycle();
      check_val("b2b_en", seen_en, 1);
      check_val("b2b_rhs", seen_rhs, 2'b01);
      repeat (2) cycle();

      // Flush in the 2nd EXEC cycle of a multi op
      issue_op(1'b1, 1'b0, 1'b1);
      w_issue_valid = 1'b0;
      cycle();
      w_flush = 1'b1;
      cycle();
      w_flush  = 1'b0;
      rv_count = 0;
      cycle();
      check_val("flush_idle", seen_busy, 0);
      repeat (6) cycle();
      check_val("flush_no_rv", rv_count, 0);

      // Flush with issue in IDLE: op dropped
      w_issue_valid = 1'b1;
      w_multi_op    = 1'b1;
      w_flush       = 1'b1;
      cycle();
      idle_inputs();
      en_count = 0;
      repeat (3) cycle();
      check_val("flush_idle_drop", en_count, 0);

      // Select sweep back-to-back
      en_rhs_q.delete();
      en_lhs_q.delete();
      for (int k = 0; k < 4; k++) issue_op(sw_sh[k], sw_im[k], 1'b0);
      idle_inputs();
      repeat (3) cycle();
      check_val("sweep_count", en_rhs_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < en_rhs_q.size()) begin
            check_val($sformatf("sweep_rhs%0d", k), en_rhs_q[k], sw_rhs[k]);
            check_val($sformatf("sweep_lhs%0d", k), en_lhs_q[k], sw_lhs[k]);
         end
      end

      // Asynchronous reset in the middle of EXEC
      issue_op(1'b1, 1'b0, 1'b1);
      w_issue_valid = 1'b0;
      cycle();
      #2;
      w_rst_n = 1'b0;
      #1;
      check_val("arst_lhs",  w_alu_lhs_ctrl, 0);
      check_val("arst_rhs",  w_alu_rhs_ctrl, 2'b01);
      check_val("arst_en",   w_alu_en,       0);
      check_val("arst_rv",   w_result_valid, 0);
      check_val("arst_busy", w_busy,         0);
      model_reset();
      @(posedge w_clk);
      #3;
      w_rst_n  = 1'b1;
      rv_count = 0;
      repeat (8) cycle();
      check_val("arst_no_rv", rv_count, 0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         w_issue_valid = ($urandom_range(0, 9) < 6);
         w_stall       = ($urandom_range(0, 9) < 3);
         w_flush       = ($urandom_range(0, 19) == 0);
         w_shift_op    = 1'($urandom_range(0, 1));
         w_imm_op      = 1'($urandom_range(0, 1));
         w_multi_op    = 1'($urandom_range(0, 1));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrlr.md
ALU_SEQ_CTRLR -- requirements
Module: alu_seq_ctrlr

Interface
REQ-001 Parameter MULTI_LAT, default 4, execute cycles for a multi-cycle op (legal range 2..15).
REQ-002 w_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 w_rst_n  in  1  asynchronous active-low reset.
REQ-004 w_issue_valid  in  1  decoded ALU op offered by decode stage.
REQ-005 w_issue_ready  out  1  controller accepts op this cycle.
REQ-006 w_imm_op  in  1  rhs operand is immediate; sampled on issue handshake.
REQ-007 w_shift_op  in  1  op is a shift; sampled on issue handshake.
REQ-008 w_multi_op  in  1  op needs MULTI_LAT execute cycles; sampled on issue handshake.
REQ-009 w_stall  in  1  downstream cannot take a result this cycle.
REQ-010 w_flush  in  1  discard in-flight op.
REQ-011 w_alu_lhs_ctrl  out  1  lhs mux select (1 = shift-amount path, 0 = register).
REQ-012 w_alu_rhs_ctrl  out  2  rhs mux select.
REQ-013 w_alu_en  out  1  ALU operating on the latched op this cycle.
REQ-014 w_result_valid  out  1  ALU result available for writeback.
REQ-015 w_busy  out  1  controller not in IDLE.

Function
REQ-016 States: IDLE, EXEC, RESP; encoding fixed in shared package.
REQ-017 Issue handshake occurs when w_issue_valid & w_issue_ready at a rising edge; imm/shift/multi latched into op registers on that edge.
REQ-018 w_issue_ready = 1 in IDLE, 1 in RESP when w_stall = 0 and w_flush = 0, else 0.
REQ-019 On handshake: state -> EXEC; latency counter loaded with MULTI_LAT-1 if multi, else 0.
REQ-020 EXEC: w_alu_en = 1; counter decrements each cycle; at counter = 0 state -> RESP next edge.
REQ-021 Single-cycle op: exactly 1 EXEC cycle; multi op: exactly MULTI_LAT EXEC cycles; result_valid one cycle after last EXEC cycle.
REQ-022 RESP: w_result_valid = 1; w_stall = 1 holds RESP with selects and result_valid stable.
REQ-023 RESP with w_stall = 0: state -> EXEC if a new handshake occurs same cycle (back-to-back, no idle bubble), else -> IDLE.
REQ-024 Selects driven from latched op registers in EXEC and RESP: shift&imm -> lhs 1, rhs 10; shift&!imm -> lhs 1, rhs 00; !shift&imm -> lhs 0, rhs 11; !shift&!imm -> lhs 0, rhs 01.
REQ-025 In IDLE selects hold their last values; w_alu_en = 0, w_result_valid = 0.
REQ-026 w_flush = 1 in any state: next state IDLE, counter cleared, no result_valid generated for flushed op; flush overrides a same-cycle issue (no handshake, ready = 0 in non-IDLE states; in IDLE ready stays 1 but the op is dropped).
REQ-027 w_stall has no effect in IDLE or EXEC; EXEC always completes unless flushed.
REQ-028 w_busy = 1 in EXEC and RESP.
REQ-029 All outputs are functions of registered state only, except w_issue_ready (depends on w_stall, w_flush).

Reset
REQ-030 w_rst_n low asynchronously forces IDLE, counter 0, op registers 0.
REQ-031 Reset output values: lhs 0, rhs 01, alu_en 0, result_valid 0, busy 0, issue_ready 1 (once w_rst_n high).
REQ-032 Reset asserted mid-EXEC or mid-RESP discards the op; no result_valid after release.

Structure
REQ-033 Shared package holds state encoding, the four select constants (SEL_RHS_SHAMT_REG 00, SEL_RHS_REG 01, SEL_RHS_SHAMT_IMM 10, SEL_RHS_IMM 11) and default MULTI_LAT.
REQ-034 One combinational sub-module alu_sel_decode maps latched {shift, imm} to {lhs, rhs}; FSM and counter stay in alu_seq_ctrlr.

Verification
REQ-035 Reset, then issue add-reg (imm 0, shift 0, multi 0) at cycle 0 -> alu_en cycle 1, result_valid cycle 2, lhs 0, rhs 01, IDLE cycle 3.
REQ-036 Issue shift-imm multi op, MULTI_LAT 4 -> alu_en cycles 1-4, result_valid cycle 5, lhs 1, rhs 10 throughout.
REQ-037 Result pending, w_stall high 3 cycles -> result_valid held 3 extra cycles, issue_ready 0, selects unchanged; stall low with valid op -> back-to-back EXEC next cycle.
REQ-038 w_flush pulsed in 2nd EXEC cycle of multi op -> IDLE next cycle, no result_valid ever; flush with issue_valid in IDLE -> no EXEC entered.
REQ-039 w_rst_n low asynchronously mid-EXEC -> outputs at reset values before next clock edge; no result_valid after release.
REQ-040 Sweep all four {shift, imm} combinations back-to-back -> rhs sequence 00, 10, 01, 11 with matching lhs 1, 1, 0, 0.
